riscv_run_ctrl: RTL and testbench
=================================

# riscv_run_ctrl

Parametrised run controller and commit-trace capture for the single-cycle RISC-V core. It sequences the core's reset release, lets the core run for a bounded number of cycles, and stops it on a cycle budget, a self-loop, or a programmed halt PC. It also records each register write-back into a trace buffer that a host or bench drains after the run, so a program can be checked without hand-timed waits.

## Interface
Parameters:
- XLEN, 32: data and PC width.
- CYCLE_W, 16: cycle counter and budget width.
- RST_CYCLES, 2: number of cycles the core is held in reset after start; must be ≥1.
- TRACE_DEPTH, 16: trace entries; must be a power of two, ≥2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE or DONE.
- max_cycles  in  CYCLE_W  RUN-cycle budget; 0 means no budget.
- halt_pc_en  in  1  enables the halt-PC match.
- halt_pc  in  XLEN  halt address.
- core_pc, core_pc_next  in  XLEN  the core's current PC and next PC.
- commit_we  in  1  the core's RegWrite.
- commit_rd  in  5  destination register.
- commit_data  in  XLEN  write-back Result.
- core_run  out  1  0 holds the core in reset; 1 lets it run.
- busy  out  1  high in RESET and RUN.
- done  out  1  high in DONE.
- halt_cause  out  2  00 none, 01 budget, 10 self-loop, 11 halt-PC.
- cycle_count  out  CYCLE_W  RUN cycles elapsed.
- trace_rd_en  in  1  pops one trace entry.
- trace_rd_pc  out  XLEN  PC of the popped entry.
- trace_rd_rd  out  5  rd of the popped entry.
- trace_rd_data  out  XLEN  data of the popped entry.
- trace_rd_valid  out  1  the trace_rd_* outputs hold a popped entry.
- trace_count  out  log2(TRACE_DEPTH)+1  entries currently stored.
- trace_overflow  out  1  sticky; at least one commit was dropped.

## Operation
- The FSM has four states: IDLE → RESET → RUN → DONE. DONE returns to RESET on start.
- **IDLE/DONE**
  - start=1 clears cycle_count, halt_cause, the trace pointers and trace_overflow.
  - The FSM then enters RESET with a reset-cycle counter of 0.
- **RESET**
  - core_run=0.
  - After RST_CYCLES cycles in RESET, the FSM enters RUN.
  - start is ignored.
- **RUN**
  - core_run=1 and cycle_count increments each cycle; it saturates at all-ones.
  - Halt conditions, evaluated every cycle on the current inputs, highest priority first:
    - halt-PC: halt_pc_en && core_pc==halt_pc.
    - self-loop: core_pc_next==core_pc.
    - budget: max_cycles≠0 && cycle_count+1==max_cycles.
  - On any halt, the next state is DONE and halt_cause latches the winning code.
  - start is ignored.
- **Trace**
  - In RUN, a commit_we=1 cycle writes {core_pc, commit_rd, commit_data}, including the halting cycle.
  - Writes with commit_rd==0 are not recorded.
  - When the buffer is full, the commit is dropped and trace_overflow is set.
  - The buffer does not wrap during a run: the first TRACE_DEPTH commits are kept.
- **Trace read**
  - Reads are allowed in any state.
  - trace_rd_en with trace_count>0 pops the oldest entry.
  - trace_rd_en with an empty buffer leaves the outputs unchanged and does not set trace_rd_valid.
  - A simultaneous commit write and pop in RUN are both performed; trace_count is unchanged.
- **Reset values**
  - State = IDLE.
  - core_run, busy, done, trace_rd_valid and trace_overflow = 0.
  - halt_cause = 00.
  - cycle_count and trace_count = 0.
  - trace_rd_* data outputs = 0.
- **Reset mid-run:** asserting rst immediately forces core_run=0 and IDLE, and discards the trace.

## Timing
- Start-to-run: start at edge N gives busy=1 and core_run=0 from N+1, and core_run=1 from edge N+1+RST_CYCLES.
- Halt: a condition true in the cycle ending at edge M gives done=1 and core_run=0 from M+1. The halting instruction's commit is recorded.
- Trace read latency: trace_rd_en at edge N gives trace_rd_* and trace_rd_valid=1 valid after N. trace_rd_valid is high for exactly one cycle per pop.
- cycle_count equals the number of RUN cycles, including the halting cycle.

## Configuration
- Macro: RUN_CTRL_TRACE_EN.
- Defined: the trace buffer and read port are implemented as described.
- Undefined:
  - No trace storage is built.
  - trace_rd_pc, trace_rd_rd, trace_rd_data, trace_rd_valid, trace_count and trace_overflow are tied to 0.
  - trace_rd_en is ignored.
  - FSM and halt behaviour are identical to the defined case.

## Test plan
- Defaults, max_cycles=8, no commits, no self-loop; start pulsed one cycle → core_run rises 3 cycles after the start edge, done after 8 RUN cycles, halt_cause=01, cycle_count=8.
- core_pc steps 0,4,8,…; halt_pc_en=1, halt_pc=0x10, max_cycles=0 → DONE after the cycle where core_pc=0x10, halt_cause=11, cycle_count=5.
- core_pc=core_pc_next=0x20 from the 3rd RUN cycle → halt_cause=10. Same stimulus with halt_pc=0x20 enabled → halt_cause=11, because halt-PC has priority.
- 20 commits with rd=5, data=0..19 and one rd=0 commit, TRACE_DEPTH=16 → trace_count=16, trace_overflow=1; 16 pops return data 0..15 in order; a 17th pop leaves trace_rd_valid=0.
- rst asserted mid-RUN, deasserted 2 cycles later, then start → IDLE immediately, core_run=0, trace_count=0; the new run starts with cycle_count=0.
- Build without RUN_CTRL_TRACE_EN and repeat the commit test → trace outputs stay 0; halt and timing results match the defined build.

Source files
------------

// File: rtl/riscv_run_ctrl.sv
// Run controller and commit-trace capture for the single-cycle RISC-V core.
// Define RUN_CTRL_TRACE_EN to build the trace buffer; otherwise trace outputs read 0.
module riscv_run_ctrl #(
   parameter int XLEN        = 32,
   parameter int CYCLE_W     = 16,
   parameter int RST_CYCLES  = 2,
   parameter int TRACE_DEPTH = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [CYCLE_W-1:0]             max_cycles,
   input  logic                           halt_pc_en,
   input  logic [XLEN-1:0]                halt_pc,
   input  logic [XLEN-1:0]                core_pc,
   input  logic [XLEN-1:0]                core_pc_next,
   input  logic                           commit_we,
   input  logic [4:0]                     commit_rd,
   input  logic [XLEN-1:0]                commit_data,
   output logic                           core_run,
   output logic                           busy,
   output logic                           done,
   output logic [1:0]                     halt_cause,
   output logic [CYCLE_W-1:0]             cycle_count,
   input  logic                           trace_rd_en,
   output logic [XLEN-1:0]                trace_rd_pc,
   output logic [4:0]                     trace_rd_rd,
   output logic [XLEN-1:0]                trace_rd_data,
   output logic                           trace_rd_valid,
   output logic [$clog2(TRACE_DEPTH):0]   trace_count,
   output logic                           trace_overflow
);

   localparam int AW = $clog2(TRACE_DEPTH);
   localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;

   state_t         state, state_nx;
   logic [RW-1:0]  rst_cnt;
   logic           rst_last;
   logic           start_ok;
   logic [1:0]     hit_cause;

   assign rst_last = (rst_cnt == RW'(RST_CYCLES - 1));
   assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));

   // Halt sources in priority order: halt-PC, self-loop, cycle budget.
   always_comb begin
      hit_cause = 2'b00;
      if (halt_pc_en && (core_pc == halt_pc))
         hit_cause = 2'b11;
      else if (core_pc_next == core_pc)
         hit_cause = 2'b10;
      else if ((max_cycles != '0) && ((cycle_count + CYCLE_W'(1)) == max_cycles))
         hit_cause = 2'b01;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = S_RESET;
         S_RESET: if (rst_last) state_nx = S_RUN;
         S_RUN:   if (hit_cause != 2'b00) state_nx = S_DONE;
         S_DONE:  if (start) state_nx = S_RESET;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      core_run = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         S_RESET: busy = 1'b1;
         S_RUN: begin
            core_run = 1'b1;
            busy     = 1'b1;
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rst_cnt     <= '0;
         cycle_count <= '0;
         halt_cause  <= 2'b00;
      end else if (start_ok) begin
         rst_cnt     <= '0;
         cycle_count <= '0;
         halt_cause  <= 2'b00;
      end else if (state == S_RESET) begin
         rst_cnt <= rst_cnt + RW'(1);
      end else if (state == S_RUN) begin
         if (cycle_count != '1) cycle_count <= cycle_count + CYCLE_W'(1);
         if (hit_cause != 2'b00) halt_cause <= hit_cause;
      end
   end

`ifdef RUN_CTRL_TRACE_EN
   logic [XLEN-1:0] mem_pc   [TRACE_DEPTH];
   logic [4:0]      mem_rd   [TRACE_DEPTH];
   logic [XLEN-1:0] mem_data [TRACE_DEPTH];
   logic [AW:0]     wr_ptr, rd_ptr;
   logic            full, commit_ok, wr_en, rd_en;

   assign trace_count = wr_ptr - rd_ptr;
   assign full        = (trace_count == (AW+1)'(TRACE_DEPTH));
   assign commit_ok   = (state == S_RUN) && commit_we && (commit_rd != 5'd0);
   assign wr_en       = commit_ok && !full;
   assign rd_en       = trace_rd_en && (trace_count != '0);

   // Storage needs no reset: only entries between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_pc[wr_ptr[AW-1:0]]   <= core_pc;
         mem_rd[wr_ptr[AW-1:0]]   <= commit_rd;
         mem_data[wr_ptr[AW-1:0]] <= commit_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         trace_overflow <= 1'b0;
         trace_rd_valid <= 1'b0;
         trace_rd_pc    <= '0;
         trace_rd_rd    <= '0;
         trace_rd_data  <= '0;
      end else begin
         trace_rd_valid <= 1'b0;
         if (start_ok) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            trace_overflow <= 1'b0;
         end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (commit_ok && full) trace_overflow <= 1'b1;
            if (rd_en) begin
               rd_ptr         <= rd_ptr + (AW+1)'(1);
               trace_rd_pc    <= mem_pc[rd_ptr[AW-1:0]];
               trace_rd_rd    <= mem_rd[rd_ptr[AW-1:0]];
               trace_rd_data  <= mem_data[rd_ptr[AW-1:0]];
               trace_rd_valid <= 1'b1;
            end
         end
      end
   end
`else
   logic unused_trace;
   assign unused_trace   = ^{trace_rd_en, commit_we, commit_rd, commit_data};
   assign trace_rd_pc    = '0;
   assign trace_rd_rd    = '0;
   assign trace_rd_data  = '0;
   assign trace_rd_valid = 1'b0;
   assign trace_count    = '0;
   assign trace_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Bench for riscv_run_ctrl: directed and random runs against a behavioural model,
// with a monitor that scores run results and trace pops from expectation queues.
module tb_riscv_run_ctrl;
   localparam int XLEN = 32;
   localparam int CW   = 16;
   localparam int RC   = 2;
   localparam int TD   = 16;
   localparam int MAXK = 64;
`ifdef RUN_CTRL_TRACE_EN
   localparam bit TRACE_ON = 1'b1;
`else
   localparam bit TRACE_ON = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [CW-1:0]   max_cycles;
   logic            halt_pc_en;
   logic [XLEN-1:0] halt_pc, core_pc, core_pc_next, commit_data;
   logic            commit_we;
   logic [4:0]      commit_rd;
   logic            core_run, busy, done;
   logic [1:0]      halt_cause;
   logic [CW-1:0]   cycle_count;
   logic            trace_rd_en;
   logic [XLEN-1:0] trace_rd_pc, trace_rd_data;
   logic [4:0]      trace_rd_rd;
   logic            trace_rd_valid;
   logic [4:0]      trace_count;
   logic            trace_overflow;

   riscv_run_ctrl #(.XLEN(XLEN), .CYCLE_W(CW), .RST_CYCLES(RC), .TRACE_DEPTH(TD)) dut (
      .clk(clk), .rst(rst), .start(start), .max_cycles(max_cycles),
      .halt_pc_en(halt_pc_en), .halt_pc(halt_pc), .core_pc(core_pc),
      .core_pc_next(core_pc_next), .commit_we(commit_we), .commit_rd(commit_rd),
      .commit_data(commit_data), .core_run(core_run), .busy(busy), .done(done),
      .halt_cause(halt_cause), .cycle_count(cycle_count), .trace_rd_en(trace_rd_en),
      .trace_rd_pc(trace_rd_pc), .trace_rd_rd(trace_rd_rd), .trace_rd_data(trace_rd_data),
      .trace_rd_valid(trace_rd_valid), .trace_count(trace_count),
      .trace_overflow(trace_overflow)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;
   logic [63:0] run_q[$];      // {halt_cause, cycle_count}
   logic [68:0] exp_q[$];      // {pc, rd, data} per expected pop

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- program description (one entry per RUN cycle) ----------------
   logic [31:0] p_pc   [MAXK+2];
   logic [31:0] p_pcn  [MAXK+2];
   logic        p_we   [MAXK+2];
   logic [4:0]  p_rd   [MAXK+2];
   logic [31:0] p_data [MAXK+2];
   logic [15:0] cfg_max;
   logic        cfg_hpe;
   logic [31:0] cfg_hp;
   int          exp_k, exp_tc;
   logic        exp_ovf;

   task automatic build_pc(input logic [31:0] base, input int loop_at);
      for (int k = 1; k <= MAXK + 1; k++)
         p_pc[k] = (loop_at != 0 && k >= loop_at) ? base + 32'(4 * (loop_at - 1))
                                                 : base + 32'(4 * (k - 1));
      for (int k = 1; k <= MAXK; k++) p_pcn[k] = p_pc[k + 1];
   endtask

   task automatic clear_commits();
      for (int k = 0; k <= MAXK + 1; k++) begin
         p_we[k] = 1'b0; p_rd[k] = 5'd0; p_data[k] = 32'd0;
      end
   endtask

   task automatic rand_prog();
      logic [31:0] base;
      int loop_at;
      base    = 32'($urandom_range(0, 1023)) << 2;
      loop_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : 0;
      build_pc(base, loop_at);
      cfg_max = (loop_at == 0 || $urandom_range(0, 1) == 1) ? 16'($urandom_range(1, 40)) : 16'd0;
      cfg_hpe = 1'($urandom_range(0, 1));
      cfg_hp  = base + 32'(4 * $urandom_range(0, 45));
      for (int k = 1; k <= MAXK; k++) begin
         p_we[k]   = ($urandom_range(0, 3) != 0);
         p_rd[k]   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         p_data[k] = $urandom;
      end
   endtask

   // Reference model: walk RUN cycles applying the halt rules, then list kept commits.
   task automatic model_run();
      logic [1:0] cause;
      int n;
      cause = 2'b00;
      exp_k = 0;
      for (int k = 1; k <= MAXK && exp_k == 0; k++) begin
         if (cfg_hpe && p_pc[k] == cfg_hp)       cause = 2'b11;
         else if (p_pcn[k] == p_pc[k])           cause = 2'b10;
         else if (cfg_max != 0 && k == int'(cfg_max)) cause = 2'b01;
         if (cause != 2'b00) exp_k = k;
      end
      run_q.push_back({46'd0, cause, 16'(exp_k)});
      n = 0;
      for (int k = 1; k <= exp_k; k++) begin
         if (p_we[k] && p_rd[k] != 5'd0) begin
            if (TRACE_ON && n < TD) exp_q.push_back({p_pc[k], p_rd[k], p_data[k]});
            n++;
         end
      end
      exp_tc  = TRACE_ON ? ((n < TD) ? n : TD) : 0;
      exp_ovf = TRACE_ON && (n > TD);
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_k(input int k);
      core_pc      = p_pc[k];
      core_pc_next = p_pcn[k];
      commit_we    = p_we[k];
      commit_rd    = p_rd[k];
      commit_data  = p_data[k];
   endtask

   // Outside RUN: a self-loop and a live commit, both of which must be ignored.
   task automatic drive_junk();
      core_pc      = 32'h40;
      core_pc_next = 32'h40;
      commit_we    = 1'b1;
      commit_rd    = 5'd7;
      commit_data  = $urandom;
   endtask

   task automatic do_run(input int abort_at);
      int lat, k, ki;
      if (abort_at == 0) model_run();
      max_cycles = cfg_max; halt_pc_en = cfg_hpe; halt_pc = cfg_hp;
      @(posedge clk); #1;
      start = 1'b1; drive_junk();
      @(posedge clk); #1;
      start = 1'b0; lat = 1;
      chk("busy_in_reset", 64'(busy), 64'd1);
      while (!core_run && lat < 10) begin
         drive_junk();
         @(posedge clk); #1;
         lat++;
      end
      chk("start_latency", 64'(lat), 64'(RC + 1));
      k = 1;
      while (core_run && k <= 100 && !(abort_at != 0 && k > abort_at)) begin
         ki = (k <= MAXK) ? k : MAXK;
         drive_k(ki);
         start = (k == 1) && (abort_at != 0 || exp_k > 1);
         @(posedge clk); #1;
         k++;
      end
      start = 1'b0; drive_junk();
      if (abort_at != 0) begin
         rst = 1'b1; #1;
         chk("abort_core_run", 64'(core_run), 64'd0);
         chk("abort_busy", 64'(busy), 64'd0);
         chk("abort_trace_count", 64'(trace_count), 64'd0);
         @(posedge clk); @(posedge clk); #1;
         rst = 1'b0;
         return;
      end
      chk("run_length", 64'(k - 1), 64'(exp_k));
      chk("done_level", 64'(done), 64'd1);
      chk("trace_count", 64'(trace_count), 64'(exp_tc));
      chk("trace_overflow", 64'(trace_overflow), 64'(exp_ovf));
      trace_rd_en = 1'b1;
      repeat (exp_tc + 1) @(posedge clk);
      #1 trace_rd_en = 1'b0;
      @(negedge clk);
      chk("pop_empty_valid", 64'(trace_rd_valid), 64'd0);
      chk("trace_drained", 64'(trace_count), 64'd0);
   endtask

   // ---------------- monitor ----------------
   logic        done_q = 1'b0;
   logic [63:0] run_e;
   logic [68:0] tr_e;

   always @(negedge clk) begin
      if (done && !done_q) begin
         if (run_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: cycle_count=%0d with no run expected", cycle_count);
         end else begin
            run_e = run_q.pop_front();
            chk("cycle_count", 64'(cycle_count), 64'(run_e[15:0]));
            chk("halt_cause", 64'(halt_cause), 64'(run_e[17:16]));
            chk("core_run_at_done", 64'(core_run), 64'd0);
         end
      end
      done_q = done;
      if (trace_rd_valid) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_pop: data=0x%0h with no entry expected", trace_rd_data);
         end else begin
            tr_e = exp_q.pop_front();
            chk("pop_pc", 64'(trace_rd_pc), 64'(tr_e[68:37]));
            chk("pop_rd", 64'(trace_rd_rd), 64'(tr_e[36:32]));
            chk("pop_data", 64'(trace_rd_data), 64'(tr_e[31:0]));
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      rst = 1'b1; start = 1'b0; max_cycles = '0; halt_pc_en = 1'b0; halt_pc = '0;
      core_pc = '0; core_pc_next = 32'd4; commit_we = 1'b0; commit_rd = '0;
      commit_data = '0; trace_rd_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_core_run", 64'(core_run), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_halt_cause", 64'(halt_cause), 64'd0);
      chk("rst_cycle_count", 64'(cycle_count), 64'd0);
      chk("rst_trace_count", 64'(trace_count), 64'd0);
      chk("rst_rd_valid", 64'(trace_rd_valid), 64'd0);
      chk("rst_rd_data", 64'(trace_rd_data), 64'd0);
      chk("rst_overflow", 64'(trace_overflow), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_busy", 64'(busy), 64'd0);

      // Budget stop after 8 RUN cycles.
      clear_commits(); build_pc(32'h0, 0);
      cfg_max = 16'd8; cfg_hpe = 1'b0; cfg_hp = 32'h0;
      do_run(0);
      // Halt-PC at 0x10.
      cfg_max = 16'd0; cfg_hpe = 1'b1; cfg_hp = 32'h10;
      do_run(0);
      // Self-loop at 0x20 from RUN cycle 3, then same with halt-PC priority.
      build_pc(32'h18, 3);
      cfg_max = 16'd0; cfg_hpe = 1'b0; cfg_hp = 32'h20;
      do_run(0);
      cfg_hpe = 1'b1;
      do_run(0);
      // 20 kept-candidate commits plus an rd=0 commit: fills and overflows the trace.
      clear_commits(); build_pc(32'h100, 0);
      for (int k = 1; k <= 20; k++) begin
         p_we[k] = 1'b1; p_rd[k] = 5'd5; p_data[k] = 32'(k - 1);
      end
      p_we[21] = 1'b1; p_rd[21] = 5'd0; p_data[21] = 32'hdead;
      cfg_max = 16'd21; cfg_hpe = 1'b0;
      do_run(0);
      // Reset in the middle of a run, then a fresh run.
      rand_prog(); build_pc(32'h200, 0);
      cfg_max = 16'd0; cfg_hpe = 1'b0;
      do_run(5);
      rand_prog();
      do_run(0);
      // Random runs.
      for (int r = 0; r < 10; r++) begin
         rand_prog();
         do_run(0);
      end

      repeat (3) @(posedge clk);
      chk("run_q_empty", 64'(run_q.size()), 64'd0);
      chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
